// File: rtl/mock_dev_pkg.sv
// Shared constants and types for the mock console-input device.
package mock_dev_pkg;

   // Register byte offsets inside the 16-byte window (only bits [3:2] decode)
   localparam logic [3:0] OFF_RXDATA = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CTRL   = 4'h8;
   localparam logic [3:0] OFF_RSVD   = 4'hC;

   // STATUS bit positions
   localparam int ST_NOT_EMPTY = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_COUNT_LSB = 8;
   localparam int ST_COUNT_W   = 8;
   localparam int ST_OVERRUN   = 16;

   // CTRL bit positions
   localparam int CTRL_IRQ_EN  = 0;
   localparam int CTRL_FLUSH   = 1;
   localparam int CTRL_OVR_CLR = 2;

   // RXDATA value returned when the FIFO is empty
   localparam logic [31:0] EMPTY_READ = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

endpackage

// File: rtl/mock_uart_rx_if.sv
// Core-side device bus between the Aquila core and the mock RX device.
interface mock_uart_rx_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();
   logic                    strobe;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    rw;
   logic [DATA_WIDTH/8-1:0] byte_enable;
   logic [DATA_WIDTH-1:0]   core2dev_data;
   logic                    data_ready;
   logic [DATA_WIDTH-1:0]   dev2core_data;

   modport master (
      output strobe, addr, rw, byte_enable, core2dev_data,
      input  data_ready, dev2core_data
   );

   modport slave (
      input  strobe, addr, rw, byte_enable, core2dev_data,
      output data_ready, dev2core_data
   );
endinterface

// File: rtl/mock_uart_rx_sync_fifo.sv
// Synchronous FIFO with flush; flush overrides a simultaneous push or pop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Next pointers and occupancy; pointers wrap naturally modulo DEPTH
   always_comb begin
      do_push  = push && !full && !flush;
      do_pop   = pop && !empty && !flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless once the pointers reset
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mock_uart_rx.sv
// Console-input responder: host pushes bytes, core pops them over M_DEVICE.
module mock_uart_rx
   import mock_dev_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hC000_0100,
   parameter int                    FIFO_DEPTH = 16,
   parameter int                    RESP_LAT   = 2
) (
   input  logic                clk,
   input  logic                rst,
   mock_uart_rx_if.slave       M_DEVICE,
   input  logic                host_valid,
   input  logic [7:0]          host_data,
   output logic                host_ready,
   output logic                irq
);
   localparam int CNT_W  = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
   localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BE_W   = DATA_WIDTH / 8;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        lat_cnt_q, lat_cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    rw_q, rw_d;
   logic [BE_W-1:0]         be_q, be_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    irq_en_q, irq_en_d;
   logic                    overrun_q, overrun_d;

   logic                    resp;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    in_window;
   logic                    fifo_pop, fifo_flush, ovr_clr;
   logic                    fifo_full, fifo_empty;
   logic [7:0]              fifo_dout;
   logic [FCNT_W-1:0]       fifo_count;
   logic                    unused_bits;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (host_valid),
      .pop   (fifo_pop),
      .flush (fifo_flush),
      .din   (host_data),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign in_window   = (addr_q[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
   assign host_ready  = ~fifo_full;
   assign irq         = irq_en_q & ~fifo_empty;
   assign unused_bits = ^{addr_q[1:0], be_q, wdata_q};

   assign M_DEVICE.data_ready    = resp;
   assign M_DEVICE.dev2core_data = rdata;

   // FSM next state, request latch, register actions and read mux
   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      irq_en_d   = irq_en_q;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
      ovr_clr    = 1'b0;
      resp       = 1'b0;
      rdata      = '0;
      case (state_q)
         IDLE: begin
            if (M_DEVICE.strobe) begin
               addr_d  = M_DEVICE.addr;
               rw_d    = M_DEVICE.rw;
               be_d    = M_DEVICE.byte_enable;
               wdata_d = M_DEVICE.core2dev_data;
               if (RESP_LAT == 1) begin
                  state_d = RESP;
               end else begin
                  lat_cnt_d = CNT_W'(RESP_LAT - 1);
                  state_d   = WAIT;
               end
            end
         end
         WAIT: begin
            lat_cnt_d = lat_cnt_q - CNT_W'(1);
            if (lat_cnt_q == CNT_W'(1)) state_d = RESP;
         end
         RESP: begin
            resp    = 1'b1;
            state_d = IDLE;
            if (in_window) begin
               case (addr_q[3:2])
                  OFF_RXDATA[3:2]: begin
                     if (!rw_q) begin
                        if (fifo_empty) begin
                           rdata[31:0] = EMPTY_READ;
                        end else begin
                           rdata[7:0] = fifo_dout;
                           fifo_pop   = 1'b1;
                        end
                     end
                  end
                  OFF_STATUS[3:2]: begin
                     if (!rw_q) begin
                        rdata[ST_NOT_EMPTY]                 = ~fifo_empty;
                        rdata[ST_FULL]                      = fifo_full;
                        rdata[ST_COUNT_LSB +: ST_COUNT_W]   = ST_COUNT_W'(fifo_count);
                        rdata[ST_OVERRUN]                   = overrun_q;
                     end
                  end
                  OFF_CTRL[3:2]: begin
                     if (rw_q) begin
                        if (be_q[0]) begin
                           irq_en_d   = wdata_q[CTRL_IRQ_EN];
                           fifo_flush = wdata_q[CTRL_FLUSH];
                           ovr_clr    = wdata_q[CTRL_OVR_CLR];
                        end
                     end else begin
                        rdata[CTRL_IRQ_EN] = irq_en_q;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
      // A fresh drop in the same cycle as a clear leaves the flag set
      overrun_d = (overrun_q & ~ovr_clr) | (host_valid & fifo_full);
   end

   // State, request latch and control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         lat_cnt_q <= '0;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         be_q      <= '0;
         wdata_q   <= '0;
         irq_en_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         addr_q    <= addr_d;
         rw_q      <= rw_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         irq_en_q  <= irq_en_d;
         overrun_q <= overrun_d;
      end
   end

endmodule
